// File: rtl/code_copy_master.sv
// Bus initiator that copies a block of 32-bit words from a source region to a
// destination region of code memory, one read/write pair per word.
module code_copy_master #(
    parameter int READ_LATENCY = 1,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iStart,
    input  logic [31:0]            iSrcAddr,
    input  logic [31:0]            iDstAddr,
    input  logic [COUNT_WIDTH-1:0] iWordCount,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oError,
    output logic                   oReadEnable,
    output logic                   oWriteEnable,
    output logic [3:0]             oByteEnable,
    output logic [31:0]            oAddress,
    output logic [31:0]            oWriteData,
    input  logic [31:0]            iReadData
);

    localparam int LW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [31:0]            r_src;
    logic [31:0]            r_dst;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic                   r_error;
    logic [LW-1:0]          r_lat_cnt;

    logic                   w_misaligned;
    logic                   w_read_last;
    logic                   w_last_word;
    logic [31:0]            w_src_next;

    logic                   w_busy;
    logic                   w_done;
    logic                   w_error;
    logic                   w_re;
    logic                   w_we;
    logic [3:0]             w_be;
    logic [31:0]            w_addr;
    logic [31:0]            w_wdata;

    assign w_misaligned = (iSrcAddr[1:0] != 2'b00) || (iDstAddr[1:0] != 2'b00);
    assign w_read_last  = (r_lat_cnt == LW'(READ_LATENCY));
    assign w_last_word  = (r_remaining == COUNT_WIDTH'(1));

    // Source address the next READ will present; advances together with r_src.
    assign w_src_next = (r_state == S_IDLE)  ? iSrcAddr :
                        (r_state == S_WRITE) ? r_src + 32'd4 :
                                               r_src;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (iStart) begin
                    if (w_misaligned || (iWordCount == '0)) begin
                        w_next_state = S_FINISH;
                    end else begin
                        w_next_state = S_READ;
                    end
                end
            end
            S_READ: begin
                if (w_read_last) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next_state = w_last_word ? S_FINISH : S_READ;
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_error = 1'b0;
        w_re    = 1'b0;
        w_we    = 1'b0;
        w_be    = 4'b0000;
        w_addr  = 32'd0;
        w_wdata = 32'd0;
        unique case (w_next_state)
            S_READ: begin
                w_busy = 1'b1;
                w_re   = 1'b1;
                w_be   = 4'b1111;
                w_addr = w_src_next;
            end
            S_WRITE: begin
                w_busy  = 1'b1;
                w_we    = 1'b1;
                w_be    = 4'b1111;
                w_addr  = r_dst;
                w_wdata = iReadData;
            end
            S_FINISH: begin
                w_busy  = 1'b1;
                w_done  = 1'b1;
                w_error = (r_state == S_IDLE) ? w_misaligned : r_error;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_src       <= 32'd0;
            r_dst       <= 32'd0;
            r_remaining <= '0;
            r_error     <= 1'b0;
            r_lat_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_src       <= iSrcAddr;
                        r_dst       <= iDstAddr;
                        r_remaining <= iWordCount;
                        r_error     <= w_misaligned;
                        r_lat_cnt   <= '0;
                    end
                end
                S_READ: begin
                    r_lat_cnt <= w_read_last ? '0 : r_lat_cnt + 1'b1;
                end
                S_WRITE: begin
                    r_src       <= r_src + 32'd4;
                    r_dst       <= r_dst + 32'd4;
                    r_remaining <= r_remaining - 1'b1;
                    r_lat_cnt   <= '0;
                end
                S_FINISH: begin
                    r_error <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oError       <= 1'b0;
            oReadEnable  <= 1'b0;
            oWriteEnable <= 1'b0;
            oByteEnable  <= 4'b0000;
            oAddress     <= 32'd0;
            oWriteData   <= 32'd0;
        end else begin
            oBusy        <= w_busy;
            oDone        <= w_done;
            oError       <= w_error;
            oReadEnable  <= w_re;
            oWriteEnable <= w_we;
            oByteEnable  <= w_be;
            oAddress     <= w_addr;
            oWriteData   <= w_wdata;
        end
    end

endmodule

// File: tb/tb_code_copy_master.sv
// Two copies of the master (read latency 1 and 3) share stimulus; each is checked
// every cycle against an expected bus trace expanded from the copy request.
module tb_code_copy_master;

    localparam int CW = 16;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic        re;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   src = 32'd0;
    logic [31:0]   dst = 32'd0;
    logic [CW-1:0] cnt = '0;

    logic          busy_o  [2];
    logic          done_o  [2];
    logic          err_o   [2];
    logic          re_o    [2];
    logic          we_o    [2];
    logic [3:0]    be_o    [2];
    logic [31:0]   addr_o  [2];
    logic [31:0]   wdata_o [2];
    logic [31:0]   rdata_i [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        code_copy_master #(
            .READ_LATENCY ((g == 0) ? 1 : 3),
            .COUNT_WIDTH  (CW)
        ) u_dut (
            .iCLK         (clk),
            .iRST         (rst),
            .iStart       (start),
            .iSrcAddr     (src),
            .iDstAddr     (dst),
            .iWordCount   (cnt),
            .oBusy        (busy_o[g]),
            .oDone        (done_o[g]),
            .oError       (err_o[g]),
            .oReadEnable  (re_o[g]),
            .oWriteEnable (we_o[g]),
            .oByteEnable  (be_o[g]),
            .oAddress     (addr_o[g]),
            .oWriteData   (wdata_o[g]),
            .iReadData    (rdata_i[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    task automatic check(input bit ok, input string name,
                         input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // Code memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    // ---------------- reference model: expected per-cycle trace ----------------
    obs_t q0[$];
    obs_t q1[$];
    bit   idle_m [2];

    task automatic push(input int g, input obs_t e);
        if (g == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic build(input int g, input logic [31:0] s, input logic [31:0] d,
                         input logic [CW-1:0] n);
        obs_t e;
        logic [31:0] offs;
        if (s[1:0] != 2'b00 || d[1:0] != 2'b00) begin
            e = '0; e.busy = 1'b1; e.done = 1'b1; e.err = 1'b1;
            push(g, e);
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            offs = 32'(i) << 2;
            for (int k = 0; k <= lat_of(g); k++) begin
                e = '0; e.busy = 1'b1; e.re = 1'b1; e.be = 4'hF; e.addr = s + offs;
                push(g, e);
            end
            e = '0; e.busy = 1'b1; e.we = 1'b1; e.be = 4'hF;
            e.addr = d + offs; e.wdata = mem_word(s + offs);
            push(g, e);
        end
        e = '0; e.busy = 1'b1; e.done = 1'b1;
        push(g, e);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q0.delete();
            q1.delete();
        end else if (start) begin
            for (int g = 0; g < 2; g++) begin
                if (idle_m[g]) build(g, src, dst, cnt);
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            obs_t e;
            obs_t a;
            bit   have;
            have = (g == 0) ? (q0.size() > 0) : (q1.size() > 0);
            e = '0;
            if (have) e = (g == 0) ? q0.pop_front() : q1.pop_front();
            idle_m[g] = !have;
            a.busy  = busy_o[g];
            a.done  = done_o[g];
            a.err   = err_o[g];
            a.re    = re_o[g];
            a.we    = we_o[g];
            a.be    = be_o[g];
            a.addr  = addr_o[g];
            a.wdata = e.we ? wdata_o[g] : 32'd0;
            if (chk_en)
                check(a === e, $sformatf("trace cyc%0d inst%0d", cyc, g), 80'(a), 80'(e));
        end
    end

    // ---------------- memory responder ----------------
    int rd_run [2];
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (re_o[g] === 1'b1) begin
                rd_run[g]++;
                rdata_i[g] = (rd_run[g] == lat_of(g) + 1) ? mem_word(addr_o[g]) : $urandom();
            end else begin
                rd_run[g] = 0;
                rdata_i[g] = $urandom();
            end
        end
    end

    // ---------------- activity log for literal checks ----------------
    int          done_cyc  [2];
    bit          err_seen  [2];
    int          rd_cycles [2];
    int          wr_cycles [2];
    logic [31:0] wr_addr0[$];
    logic [31:0] wr_data0[$];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (done_o[g] === 1'b1) begin
                done_cyc[g] = cyc;
                err_seen[g] = err_o[g];
            end
            if (re_o[g] === 1'b1) rd_cycles[g]++;
            if (we_o[g] === 1'b1) begin
                wr_cycles[g]++;
                if (g == 0) begin
                    wr_addr0.push_back(addr_o[g]);
                    wr_data0.push_back(wdata_o[g]);
                end
            end
        end
    end

    task automatic clear_log();
        for (int g = 0; g < 2; g++) begin
            done_cyc[g]  = -1;
            err_seen[g]  = 1'b0;
            rd_cycles[g] = 0;
            wr_cycles[g] = 0;
        end
        wr_addr0.delete();
        wr_data0.delete();
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d,
                              input logic [CW-1:0] n, output int t0);
        @(negedge clk);
        clear_log();
        src = s; dst = d; cnt = n; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        src = $urandom(); dst = $urandom(); cnt = CW'($urandom());
    endtask

    task automatic wait_done(input int bound, input string name);
        int k = 0;
        while ((done_cyc[0] < 0 || done_cyc[1] < 0) && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (done_cyc[0] < 0 || done_cyc[1] < 0)
            check(1'b0, {name, " done timeout"}, 80'(k), 80'(bound));
        repeat (2) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        check(act == exp, name, 80'(act), 80'(exp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int nwr;
        logic [31:0] s;
        logic [31:0] d;
        logic [CW-1:0] n;
        obs_t z;

        clear_log();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        z = {busy_o[0], done_o[0], err_o[0], re_o[0], we_o[0], be_o[0], addr_o[0], wdata_o[0]};
        check(z === '0, "reset outputs", 80'(z), 80'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Three-word copy from address 0.
        start_copy(32'h0000_0000, 32'h0040_0000, CW'(3), t0);
        wait_done(80, "copy3");
        chk("copy3 done latency L1", done_cyc[0] - t0, 10);
        chk("copy3 done latency L3", done_cyc[1] - t0, 16);
        chk("copy3 error", int'(err_seen[0]), 0);
        chk("copy3 read cycles L1", rd_cycles[0], 6);
        chk("copy3 write count", wr_addr0.size(), 3);
        for (int i = 0; i < wr_addr0.size() && i < 3; i++) begin
            chk($sformatf("copy3 waddr%0d", i), int'(wr_addr0[i]), 32'h0040_0000 + 4 * i);
            check(wr_data0[i] == mem_word(32'(4 * i)), $sformatf("copy3 wdata%0d", i),
                  80'(wr_data0[i]), 80'(mem_word(32'(4 * i))));
        end

        // Zero-length copy.
        start_copy(32'h0000_0100, 32'h0040_0100, CW'(0), t0);
        wait_done(20, "zero");
        chk("zero done latency", done_cyc[0] - t0, 1);
        chk("zero error", int'(err_seen[0]), 0);
        chk("zero bus cycles", rd_cycles[0] + wr_cycles[0] + rd_cycles[1] + wr_cycles[1], 0);

        // Misaligned source, then an aligned copy.
        start_copy(32'h0000_0002, 32'h0040_0000, CW'(3), t0);
        wait_done(20, "misalign");
        chk("misalign done latency", done_cyc[0] - t0, 1);
        chk("misalign error", int'(err_seen[0]), 1);
        chk("misalign bus cycles", rd_cycles[0] + wr_cycles[0], 0);
        start_copy(32'h0000_0010, 32'h0040_0010, CW'(1), t0);
        wait_done(30, "after misalign");
        chk("after misalign latency L1", done_cyc[0] - t0, 4);
        chk("after misalign error", int'(err_seen[0]), 0);

        // Reset during the second write of a four-word copy.
        start_copy(32'h0000_0020, 32'h0040_0100, CW'(4), t0);
        nwr = 0;
        for (int k = 0; k < 40 && nwr < 2; k++) begin
            if (we_o[0] === 1'b1) nwr++;
            if (nwr < 2) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("reset writes L1", wr_cycles[0], 2);
        chk("reset writes L3", wr_cycles[1], 1);
        chk("reset no done", done_cyc[0] + done_cyc[1], -2);

        // Start re-pulsed mid-copy is ignored.
        start_copy(32'h0000_1000, 32'h0040_0200, CW'(3), t0);
        repeat (3) @(negedge clk);
        src = 32'h0000_2000; dst = 32'h0040_0800; cnt = CW'(5); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(80, "restart");
        chk("restart done latency", done_cyc[0] - t0, 10);
        chk("restart write count", wr_cycles[0], 3);
        if (wr_addr0.size() == 3) chk("restart last waddr", int'(wr_addr0[2]), 32'h0040_0208);

        // Source wraps past the top of the address space.
        start_copy(32'hFFFF_FFFC, 32'h0040_0000, CW'(2), t0);
        wait_done(60, "wrap");
        chk("wrap done latency L3", done_cyc[1] - t0, 11);
        chk("wrap done latency L1", done_cyc[0] - t0, 7);
        chk("wrap read cycles L3", rd_cycles[1], 8);
        if (wr_data0.size() == 2)
            check(wr_data0[1] == mem_word(32'd0), "wrap wdata1", 80'(wr_data0[1]), 80'(mem_word(32'd0)));

        // Randomized copies, with misalignment, restarts and resets mixed in.
        for (int it = 0; it < 40; it++) begin
            s = $urandom() & ~32'd3;
            d = $urandom() & ~32'd3;
            if ($urandom_range(0, 7) == 0) s = 32'hFFFF_FFF0 | (s & 32'hC);
            if ($urandom_range(0, 7) == 0) d = 32'hFFFF_FFF0 | (d & 32'hC);
            if ($urandom_range(0, 5) == 0) s[0] = 1'b1;
            if ($urandom_range(0, 5) == 0) d[1] = 1'b1;
            n = CW'($urandom_range(0, 4));
            start_copy(s, d, n, t0);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                src = $urandom() & ~32'd3; dst = $urandom() & ~32'd3;
                cnt = CW'($urandom_range(0, 3)); start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 15)) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                repeat (2) @(negedge clk);
            end else begin
                wait_done(int'(n) * 5 + 40, "random");
            end
        end
        repeat (60) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
